// File: rtl/mem_interface.sv
// mem_interface
//   Memory-side stage that sits directly behind the data path's MAR/MDR.
//   It owns a byte-addressed, big-endian memory array and serialises each
//   access into one byte beat per clock after WAIT_CYCLES wait states. It
//   then completes a four-phase MOV/MOC handshake with the requester.
//
// Parameters
//   WAIT_CYCLES  wait-state edges before the first byte beat (0 allowed)
//   ADDR_W       byte address width; array depth is 2**ADDR_W bytes
//
// Ports
//   main_clk   in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   MOV        in   memory operation valid, held until MOC is seen
//   RW         in   1 = read, 0 = write
//   DL         in   data length: 00 byte, 01 halfword, 1x word
//   address    in   byte address (low bits cleared to align the access)
//   data_in    in   write data, right-justified
//   data_out   out  read data, zero-extended, right-justified
//   MOC        out  memory operation complete (registered)
//   busy       out  high whenever the FSM is not idle
//   align_err  out  the current/last access had non-zero alignment bits
module mem_interface #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        DL,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              busy,
  output logic              align_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  // The WAIT state ends on the edge where the counter reaches this value.
  // With WAIT_CYCLES == 0 the WAIT state is never entered.
  localparam logic [15:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 16'(WAIT_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  state_t            state;
  logic              rw_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        last_beat;
  logic [1:0]        beat_cnt;
  logic [15:0]       wait_cnt;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        wr_byte;
  logic              wr_en;

  logic [7:0] mem [DEPTH];

  // Beat k touches aligned_addr+k and wraps naturally in ADDR_W bits. The
  // write byte is picked big-endian: beat 0 carries the most significant
  // byte of the latched data for the access length.
  always_comb begin
    beat_addr = addr_q + ADDR_W'(beat_cnt);
    wr_byte   = 8'h00;
    case (2'(last_beat - beat_cnt))
      2'd0:    wr_byte = data_q[7:0];
      2'd1:    wr_byte = data_q[15:8];
      2'd2:    wr_byte = data_q[23:16];
      default: wr_byte = data_q[31:24];
    endcase
    // A beat is skipped if MOV has dropped (abort) or reset is asserted
    // on the same edge, so truncated writes stop at the last full beat.
    wr_en = reset && (state == XFER) && MOV && !rw_q;
  end

  // The memory array is never reset. It keeps its contents across resets
  // and aborts.
  always_ff @(posedge main_clk) begin
    if (wr_en) begin
      mem[beat_addr] <= wr_byte;
    end
  end

  // Control FSM with registered MOC/busy/align_err/data_out. Every input
  // is latched on the IDLE sampling edge. Later input changes are ignored
  // until the FSM is back in IDLE.
  always_ff @(posedge main_clk) begin
    if (!reset) begin
      state     <= IDLE;
      MOC       <= 1'b0;
      busy      <= 1'b0;
      align_err <= 1'b0;
      data_out  <= 32'h0;
      beat_cnt  <= 2'd0;
      wait_cnt  <= 16'd0;
      rw_q      <= 1'b0;
      data_q    <= 32'h0;
      addr_q    <= '0;
      last_beat <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            rw_q     <= RW;
            data_q   <= data_in;
            beat_cnt <= 2'd0;
            wait_cnt <= 16'd0;
            busy     <= 1'b1;
            if (RW) begin
              data_out <= 32'h0;
            end
            case (DL)
              2'b00: begin
                addr_q    <= address;
                last_beat <= 2'd0;
                align_err <= 1'b0;
              end
              2'b01: begin
                addr_q    <= {address[ADDR_W-1:1], 1'b0};
                last_beat <= 2'd1;
                align_err <= address[0];
              end
              default: begin
                addr_q    <= {address[ADDR_W-1:2], 2'b00};
                last_beat <= 2'd3;
                align_err <= |address[1:0];
              end
            endcase
            state <= (WAIT_CYCLES == 0) ? XFER : WAIT;
          end
        end

        WAIT: begin
          if (!MOV) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= XFER;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        XFER: begin
          if (!MOV) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (rw_q) begin
              data_out <= {data_out[23:0], mem[beat_addr]};
            end
            if (beat_cnt == last_beat) begin
              state <= DONE;
              MOC   <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 2'd1;
            end
          end
        end

        DONE: begin
          // Four-phase handshake: MOV must drop before another access.
          if (!MOV) begin
            state <= IDLE;
            MOC   <= 1'b0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          MOC   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface
//   Self-checking bench for mem_interface (WAIT_CYCLES=2, ADDR_W=9).
//   A byte-array reference model holds the expected memory contents. It
//   computes read values, completion latency and the alignment flag from
//   the access rules.
module tb_mem_interface;

  localparam int WAIT = 2;
  localparam int AW   = 9;
  localparam int SIZE = 512;

  logic          main_clk = 1'b0;
  logic          reset    = 1'b0;
  logic          MOV      = 1'b0;
  logic          RW       = 1'b0;
  logic [1:0]    DL       = 2'b00;
  logic [AW-1:0] address  = '0;
  logic [31:0]   data_in  = 32'h0;
  logic [31:0]   data_out;
  logic          MOC;
  logic          busy;
  logic          align_err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_m [SIZE];
  logic [31:0] exp_dout = 32'h0;

  mem_interface #(
    .WAIT_CYCLES(WAIT),
    .ADDR_W     (AW)
  ) dut (
    .main_clk (main_clk),
    .reset    (reset),
    .MOV      (MOV),
    .RW       (RW),
    .DL       (DL),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .MOC      (MOC),
    .busy     (busy),
    .align_err(align_err)
  );

  // Free-running clock. Stimulus is driven and outputs are sampled on the
  // falling edge, away from the active edge.
  always #5 main_clk = ~main_clk;

  // Backstop against a hung run.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int nBytes(input logic [1:0] dl);
    if (dl == 2'b00) return 1;
    if (dl == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int alignAddr(input int addr, input int n);
    return addr - (addr % n);
  endfunction

  function automatic logic [31:0] modelRead(input int base, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(mem_m[(base + k) % SIZE]);
    return v;
  endfunction

  task automatic modelWrite(input int base, input int n, input logic [31:0] v, input int beats);
    for (int k = 0; k < beats; k++) mem_m[(base + k) % SIZE] = 8'((v >> (8 * (n - 1 - k))) & 32'hFF);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete access. Inputs are scrambled after the sampling edge to
  // show they are ignored. MOV can be held past MOC before it drops.
  task automatic applyStimulus(input logic rw, input logic [1:0] dl, input int addr,
                               input logic [31:0] wdata, input int hold_extra);
    int n, base, lat;
    logic exp_align;
    n         = nBytes(dl);
    base      = alignAddr(addr, n);
    exp_align = (base != addr);
    if (rw) exp_dout = modelRead(base, n);
    else    modelWrite(base, n, wdata, n);

    @(negedge main_clk);
    RW = rw; DL = dl; address = AW'(addr); data_in = wdata; MOV = 1'b1;
    lat = -1;
    for (int e = 0; e < 64; e++) begin
      @(negedge main_clk);
      if (e == 0) begin
        checkOutput("busy_started", 32'(busy), 32'd1);
        RW = 1'($urandom); DL = 2'($urandom); address = AW'($urandom); data_in = $urandom;
      end
      if (MOC) begin
        lat = e;
        break;
      end
    end
    checkOutput("moc_latency", 32'(lat), 32'(WAIT + n));
    checkOutput("data_out", data_out, exp_dout);
    checkOutput("align_err", 32'(align_err), 32'(exp_align));
    for (int h = 0; h < hold_extra; h++) begin
      @(negedge main_clk);
      checkOutput("moc_hold", 32'(MOC), 32'd1);
      checkOutput("busy_hold", 32'(busy), 32'd1);
    end
    MOV = 1'b0;
    @(negedge main_clk);
    checkOutput("moc_drop", 32'(MOC), 32'd0);
    checkOutput("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset state.
    reset = 1'b0;
    repeat (2) @(negedge main_clk);
    checkOutput("rst_moc", 32'(MOC), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_align", 32'(align_err), 32'd0);
    checkOutput("rst_dout", data_out, 32'h0);
    reset = 1'b1;

    // Fill the whole array so later random reads never see unwritten bytes.
    for (int a = 0; a < SIZE; a += 4) applyStimulus(1'b0, 2'b10, a, $urandom, 0);

    // Word write/read and big-endian byte reads.
    applyStimulus(1'b0, 2'b10, 'h010, 32'hDEADBEEF, 0);
    applyStimulus(1'b1, 2'b10, 'h010, 32'h0, 0);
    checkOutput("lit_word", data_out, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b00, 'h010, 32'h0, 0);
    checkOutput("lit_byte10", data_out, 32'h000000DE);
    applyStimulus(1'b1, 2'b00, 'h013, 32'h0, 0);
    checkOutput("lit_byte13", data_out, 32'h000000EF);

    // Byte and halfword writes assembled into a word.
    applyStimulus(1'b0, 2'b00, 'h020, 32'h00, 0);
    applyStimulus(1'b0, 2'b00, 'h021, 32'h7A, 0);
    applyStimulus(1'b0, 2'b01, 'h022, 32'h1234, 0);
    applyStimulus(1'b1, 2'b10, 'h020, 32'h0, 0);
    checkOutput("lit_mixed", data_out, 32'h007A1234);

    // A misaligned word read is performed at the aligned address.
    applyStimulus(1'b1, 2'b10, 'h013, 32'h0, 0);
    checkOutput("lit_misalign", data_out, 32'hDEADBEEF);
    checkOutput("lit_align_set", 32'(align_err), 32'd1);
    applyStimulus(1'b1, 2'b00, 'h011, 32'h0, 0);
    checkOutput("lit_align_clr", 32'(align_err), 32'd0);

    // MOV held past MOC never retriggers.
    applyStimulus(1'b1, 2'b10, 'h010, 32'h0, 5);

    // Abort after two beats of a word write.
    applyStimulus(1'b0, 2'b10, 'h040, 32'h0, 0);
    @(negedge main_clk);
    RW = 1'b0; DL = 2'b10; address = AW'('h040); data_in = 32'hAABBCCDD; MOV = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(negedge main_clk);
      checkOutput("abort_no_moc", 32'(MOC), 32'd0);
    end
    MOV = 1'b0;
    @(negedge main_clk);
    checkOutput("abort_moc", 32'(MOC), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_dout", data_out, exp_dout);
    modelWrite('h040, 4, 32'hAABBCCDD, 2);
    applyStimulus(1'b1, 2'b10, 'h040, 32'h0, 0);
    checkOutput("lit_abort", data_out, 32'hAABB0000);

    // Top of the address space, including the DL=11 word alias.
    applyStimulus(1'b0, 2'b10, 'h1FC, 32'h01020304, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'b00, 'h1FC + k, 32'h0, 0);
      checkOutput("lit_top_byte", data_out, 32'(k + 1));
    end
    applyStimulus(1'b1, 2'b11, 'h1FC, 32'h0, 0);
    checkOutput("lit_dl11", data_out, 32'h01020304);

    // Reset during XFER of a word write: only the first beat lands.
    applyStimulus(1'b0, 2'b10, 'h080, 32'h11223344, 0);
    @(negedge main_clk);
    RW = 1'b0; DL = 2'b10; address = AW'('h080); data_in = 32'h99887766; MOV = 1'b1;
    repeat (4) @(negedge main_clk);
    reset = 1'b0;
    MOV   = 1'b0;
    @(negedge main_clk);
    checkOutput("midrst_moc", 32'(MOC), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_dout", data_out, 32'h0);
    exp_dout = 32'h0;
    modelWrite('h080, 4, 32'h99887766, 1);
    reset = 1'b1;
    applyStimulus(1'b1, 2'b10, 'h080, 32'h0, 0);
    checkOutput("lit_midrst", data_out, 32'h99223344);

    // Random mix of reads and writes of every length.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), int'($urandom_range(0, SIZE - 1)),
                    $urandom, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory-side stage directly downstream of the data path's MAR/MDR. Consumes MOV/RW/DL/address/write data and produces read data plus the MOC completion handshake.
- Owns a byte-addressed, big-endian internal memory array and serialises each access into byte beats after a configurable wait-state count.
- Models real memory latency so the control unit's MOC wait states are exercised.

Parameters:
- WAIT_CYCLES, 2, wait-state cycles before the first byte beat (0 allowed).
- ADDR_W, 9, byte address width; array depth is 2**ADDR_W bytes.

Ports:
- main_clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- MOV  input  1  memory operation valid; held high by the requester until MOC is seen.
- RW  input  1  1 = read, 0 = write.
- DL  input  2  data length: 00 byte, 01 halfword, 10 word, 11 word (alias of 10).
- address  input  ADDR_W  byte address.
- data_in  input  32  write data; right-justified for byte and halfword.
- data_out  output  32  read data, zero-extended, right-justified.
- MOC  output  1  memory operation complete.
- busy  output  1  high in every state except IDLE.
- align_err  output  1  latched misalignment flag for the current/last access.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE, MOC=0, busy=0, align_err=0, data_out=0, beat and wait counters=0. The memory array is NOT cleared.
- FSM states are IDLE, WAIT, XFER, DONE.
- IDLE:
  - On an edge with MOV=1, latch RW, DL, data_in and the aligned address.
  - Halfword accesses clear bit 0; word accesses clear bits [1:0].
  - align_err = 1 if any cleared bit was 1, else 0.
  - Clear the data_out accumulator on a read.
  - Next state is WAIT, or XFER directly if WAIT_CYCLES==0.
- WAIT: count WAIT_CYCLES edges (including the entry edge's successor), then go to XFER.
- XFER: one byte per edge, N = 1/2/4 for byte/halfword/word.
  - Beat k accesses aligned_addr+k, with k=0 the most significant byte (big-endian).
  - Read: shift the byte into the accumulator.
  - Write: array[aligned_addr+k] <= byte (N-1-k) of the latched data, where byte 0 = data[7:0].
  - After the last beat, go to DONE.
- Address arithmetic wraps modulo 2**ADDR_W.
- DONE:
  - MOC=1.
  - data_out holds the final read value; it is unchanged for writes.
  - Stay in DONE while MOV=1; on an edge with MOV=0, go to IDLE and drop MOC.
  - The handshake is four-phase, so a MOV held high never retriggers.
- Latency: counting the IDLE sampling edge as edge 0, MOC is high after edge WAIT_CYCLES+N.
  - Word, WAIT=2: edge 6. Byte, WAIT=0: edge 1.
- Abort: MOV=0 sampled in WAIT or XFER returns to IDLE next edge with MOC never asserted.
  - Bytes already written stay written.
  - data_out keeps its partial value.
- Input isolation: changes to RW/DL/address/data_in after the IDLE sampling edge are ignored until the next IDLE.
- MOC is registered; it is never combinationally derived from MOV.
- Reset mid-operation: reset dominates in any state and returns to IDLE per the reset values. An in-flight write is truncated at the last completed beat.
- A read of never-written locations returns X in simulation; the bench must write first.

Test Plan:
- Word write then word read, WAIT=2: write 0xDEADBEEF @0x010, drop MOV after MOC, then read @0x010. Required: MOC rises 6 edges after sampling, data_out=0xDEADBEEF, byte read @0x010 returns 0x000000DE, byte read @0x013 returns 0x000000EF.
- Byte/halfword write: byte 0x7A @0x021, halfword 0x1234 @0x022. Required: word read @0x020 returns 0xXX7A1234, with byte 0x020 pre-written to 0x00, i.e. 0x007A1234. Byte-write MOC appears after 3 edges.
- Misalignment: word read @0x013 (bit pattern 0b11). Required: align_err=1, access performed at 0x010, data_out=0xDEADBEEF. A following aligned access clears align_err to 0.
- Handshake hold/abort: hold MOV high 5 edges past MOC. Required: MOC stays 1 and no second access occurs. Separately, start a word write of 0xAABBCCDD @0x040 over old 0x00000000 and drop MOV after edge 4 (WAIT=2, i.e. two beats). Required: MOC never rises, then word read @0x040 = 0xAABB0000.
- Wrap-around: word write 0x01020304 @0x1FC, then byte reads @0x1FC..0x1FF return 0x01..0x04. For DL=11, a read @0x1FC returns 0x01020304.
- Reset mid-operation: assert reset=0 during XFER of a word write. Required: next edge MOC=0, busy=0, data_out=0. After release, a new read completes normally with MOC at edge WAIT_CYCLES+N.
